// File: rtl/vga_pixel_writer_if.sv
// Pixel request stream into vga_pixel_writer: a valid/ready handshake carrying one {x, y, val} triple.
interface vga_pixel_writer_if;
    logic        px_valid;
    logic        px_ready;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic [7:0]  px_val;

    modport master (output px_valid, px_x, px_y, px_val, input px_ready);
    modport slave  (input px_valid, px_x, px_y, px_val, output px_ready);
endinterface

// File: rtl/vga_pixel_writer.sv
// Buffers pixel requests in a small FIFO and replays each one as five Avalon-MM register
// writes to a VGA peripheral, followed by a fixed settle gap. SETTLE must be at least 1.
module vga_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 3
) (
    input  logic              clk,
    input  logic              reset,
    vga_pixel_writer_if.slave px,
    output logic [2:0]        address,
    output logic [7:0]        writedata,
    output logic              write,
    output logic              chipselect,
    input  logic              waitrequest,
    output logic              busy,
    output logic              err,
    output logic [15:0]       px_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {IDLE, W_H1, W_H2, W_V1, W_V2, W_R, SETTLE_WAIT} state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [7:0]  val;
    } pixel_t;

    state_t        state;
    pixel_t        mem [FIFO_DEPTH];
    pixel_t        head;
    pixel_t        hold;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [CW-1:0] settle_cnt;
    logic          accept;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          empty;
    logic          settle_done;

    assign accept      = px.px_valid && px.px_ready;
    assign in_range    = (px.px_x <= 11'd639) && (px.px_y <= 10'd479);
    assign push        = accept && in_range;
    assign empty       = (count == '0);
    assign head        = mem[rd_ptr];
    assign settle_done = (settle_cnt == CW'(SETTLE - 1));
    assign pop         = !empty && ((state == IDLE) || ((state == SETTLE_WAIT) && settle_done));
    assign busy        = !empty || (state != IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (AW + 1)'(1);
        else if (pop && !push)
            count_next = count - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {px.px_x, px.px_y, px.px_val};
    end

    // px_ready is registered from the next occupancy, so a full FIFO never sees a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            px.px_ready <= 1'b1;
            err         <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count       <= count_next;
            px.px_ready <= (count_next != (AW + 1)'(FIFO_DEPTH));
            if (accept && !in_range)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            settle_cnt <= '0;
            address    <= 3'd0;
            writedata  <= 8'd0;
            write      <= 1'b0;
            chipselect <= 1'b0;
            px_count   <= 16'd0;
        end else if (pop) begin
            hold       <= head;
            state      <= W_H1;
            address    <= 3'd3;
            writedata  <= {5'b0, head.x[10:8]};
            write      <= 1'b1;
            chipselect <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                W_H1: if (!waitrequest) begin
                    state     <= W_H2;
                    address   <= 3'd4;
                    writedata <= hold.x[7:0];
                end
                W_H2: if (!waitrequest) begin
                    state     <= W_V1;
                    address   <= 3'd5;
                    writedata <= {6'b0, hold.y[9:8]};
                end
                W_V1: if (!waitrequest) begin
                    state     <= W_V2;
                    address   <= 3'd6;
                    writedata <= hold.y[7:0];
                end
                W_V2: if (!waitrequest) begin
                    state     <= W_R;
                    address   <= 3'd0;
                    writedata <= hold.val;
                end
                W_R: if (!waitrequest) begin
                    state      <= SETTLE_WAIT;
                    address    <= 3'd0;
                    writedata  <= 8'd0;
                    write      <= 1'b0;
                    chipselect <= 1'b0;
                    settle_cnt <= '0;
                    px_count   <= px_count + 16'd1;
                end
                SETTLE_WAIT: begin
                    if (settle_done)
                        state <= IDLE;
                    else
                        settle_cnt <= settle_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
